// File: rtl/decode_issue_ctrl.sv
// Decode-stage sequencer: 2-entry skid buffer between fetch and EX, with head-opcode
// classification for the immediate extender and a saturating illegal-opcode counter.
module decode_issue_ctrl #(
  parameter int XLEN      = 32,
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 instr_valid,
  input  logic [XLEN-1:0]      instr,
  input  logic [XLEN-1:0]      pc,
  output logic                 instr_ready,
  output logic                 dec_valid,
  input  logic                 dec_ready,
  output logic [XLEN-1:0]      InstrD,
  output logic [XLEN-1:0]      PCD,
  output logic [24:0]          Imm,
  output logic [2:0]           ImmSrcD,
  output logic                 illegal,
  output logic [ILL_CNT_W-1:0] ill_cnt
);

  // state | meaning
  // EMPTY | no buffered instruction
  // ONE   | head entry valid
  // FULL  | head and skid entries valid, fetch stalled
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t            state, state_next;
  logic            ready_q;
  logic [XLEN-1:0] head_instr, head_pc, skid_instr, skid_pc;
  logic            head_load, head_from_skid, skid_load;
  logic            accept, issue;
  logic [2:0]      src_raw;
  logic            ill_raw;

  assign accept    = instr_valid & ready_q;
  assign dec_valid = (state != EMPTY);
  assign issue     = dec_valid & dec_ready;

  always_comb begin
    state_next     = state;
    head_load      = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_next = ONE;
          head_load  = 1'b1;
        end
      end
      ONE: begin
        if (accept && !issue) begin
          state_next = FULL;
          skid_load  = 1'b1;
        end else if (accept && issue) begin
          head_load = 1'b1;
        end else if (issue) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (issue) begin
          state_next     = ONE;
          head_load      = 1'b1;
          head_from_skid = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
    // Redirect discards everything, including an instruction accepted this cycle.
    if (flush) begin
      state_next     = EMPTY;
      head_load      = 1'b0;
      head_from_skid = 1'b0;
      skid_load      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      ready_q    <= 1'b1;
      head_instr <= '0;
      head_pc    <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
      ill_cnt    <= '0;
    end else begin
      state   <= state_next;
      ready_q <= (state_next != FULL);
      if (head_load) begin
        head_instr <= head_from_skid ? skid_instr : instr;
        head_pc    <= head_from_skid ? skid_pc    : pc;
      end
      if (skid_load) begin
        skid_instr <= instr;
        skid_pc    <= pc;
      end
      if (issue && illegal && (ill_cnt != '1))
        ill_cnt <= ill_cnt + ILL_CNT_W'(1);
    end
  end

  always_comb begin
    src_raw = 3'b111;
    ill_raw = 1'b0;
    case (head_instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: src_raw = 3'b000;
      7'b0100011:                         src_raw = 3'b001;
      7'b1100011:                         src_raw = 3'b010;
      7'b1101111:                         src_raw = 3'b011;
      7'b0110111, 7'b0010111:             src_raw = 3'b100;
      7'b0110011, 7'b1110011, 7'b0001111: src_raw = 3'b111;
      default:                            ill_raw = 1'b1;
    endcase
  end

  assign instr_ready = ready_q;
  assign InstrD      = head_instr;
  assign PCD         = head_pc;
  assign Imm         = head_instr[31:7];
  assign ImmSrcD     = dec_valid ? src_raw : 3'b111;
  assign illegal     = dec_valid & ill_raw;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Scoreboard bench for decode_issue_ctrl: driver pushes expected issues on accept,
// monitor compares the head against the queue every cycle.
module tb_decode_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush, instr_valid, dec_ready;
  logic [31:0] instr, pc;
  logic        instr_ready, dec_valid, illegal;
  logic [31:0] InstrD, PCD;
  logic [24:0] Imm;
  logic [2:0]  ImmSrcD;
  logic [7:0]  ill_cnt;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [31:0] i;
    logic [31:0] p;
    logic [2:0]  s;
    logic        il;
  } exp_t;
  exp_t sb[$];

  decode_issue_ctrl #(.XLEN(32), .ILL_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .flush(flush), .instr_valid(instr_valid),
    .instr(instr), .pc(pc), .instr_ready(instr_ready), .dec_valid(dec_valid),
    .dec_ready(dec_ready), .InstrD(InstrD), .PCD(PCD), .Imm(Imm),
    .ImmSrcD(ImmSrcD), .illegal(illegal), .ill_cnt(ill_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: head must match queue front; pop on issue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (dec_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue actual=%h required=none", InstrD);
        end else begin
          chk("InstrD", InstrD, sb[0].i);
          chk("PCD", PCD, sb[0].p);
          chk("Imm", 32'(Imm), 32'(sb[0].i[31:7]));
          chk("ImmSrcD", 32'(ImmSrcD), 32'(sb[0].s));
          chk("illegal", 32'(illegal), 32'(sb[0].il));
          if (dec_ready) void'(sb.pop_front());
        end
      end else begin
        chk("idle_ImmSrcD", 32'(ImmSrcD), 32'd7);
        chk("idle_illegal", 32'(illegal), 32'd0);
      end
    end
  end

  task automatic send(input logic [31:0] i, input logic [31:0] p, input logic [2:0] s,
                      input logic il, output int waits);
    bit done = 1'b0;
    instr_valid = 1'b1;
    instr = i;
    pc = p;
    waits = 0;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      if (instr_ready) begin
        sb.push_back('{i, p, s, il});
        done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=stalled required=accept instr=%h", i);
    end
  endtask

  task automatic drain();
    bit empty = 1'b0;
    for (int k = 0; k < 200 && !empty; k++) begin
      @(posedge clk);
      #1;
      empty = (sb.size() == 0);
    end
    if (!empty) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b1; flush = 1'b0; instr_valid = 1'b0; dec_ready = 1'b0;
    instr = '0; pc = '0;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_instr_ready", 32'(instr_ready), 32'd1);
    chk("rst_InstrD", InstrD, 32'd0);
    chk("rst_PCD", PCD, 32'd0);
    chk("rst_ill_cnt", 32'(ill_cnt), 32'd0);
    @(posedge clk);
    #1;

    // single addi, one-cycle latency
    dec_ready = 1'b1;
    send(32'h00500093, 32'h0, 3'b000, 1'b0, w);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("lat_dec_valid", 32'(dec_valid), 32'd1);
    chk("lat_InstrD", InstrD, 32'h00500093);
    chk("lat_Imm", 32'(Imm), 32'h0000A001);
    chk("lat_ImmSrcD", 32'(ImmSrcD), 32'd0);
    @(posedge clk);
    #1;
    drain();

    // back-to-back stream, fetch never stalled
    send(32'h00112023, 32'h4,  3'b001, 1'b0, w); chk("stream_ready0", w, 0);
    send(32'h00208463, 32'h8,  3'b010, 1'b0, w); chk("stream_ready1", w, 0);
    send(32'h008000EF, 32'hC,  3'b011, 1'b0, w); chk("stream_ready2", w, 0);
    send(32'h123450B7, 32'h10, 3'b100, 1'b0, w); chk("stream_ready3", w, 0);
    instr_valid = 1'b0;
    drain();

    // backpressure: two fill the buffer, third waits
    dec_ready = 1'b0;
    send(32'h002081B3, 32'h20, 3'b111, 1'b0, w); chk("bp_acc0", w, 0);
    send(32'h0000A103, 32'h24, 3'b000, 1'b0, w); chk("bp_acc1", w, 0);
    fork
      send(32'h00001517, 32'h28, 3'b100, 1'b0, w);
      begin
        @(negedge clk); chk("full_ready_a", 32'(instr_ready), 32'd0);
        @(negedge clk); chk("full_ready_b", 32'(instr_ready), 32'd0);
        @(posedge clk); #1; dec_ready = 1'b1;
      end
    join
    chk("bp_third_waits", w, 3);
    instr_valid = 1'b0;
    drain();

    // flush while FULL with a concurrent instruction
    dec_ready = 1'b0;
    send(32'h00000073, 32'h30, 3'b111, 1'b0, w);
    send(32'h0000000F, 32'h34, 3'b111, 1'b0, w);
    instr = 32'hDEADBEEF; pc = 32'h38; instr_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; instr_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("flush_dec_valid", 32'(dec_valid), 32'd0);
    chk("flush_instr_ready", 32'(instr_ready), 32'd1);
    @(posedge clk); #1;
    dec_ready = 1'b1;
    send(32'h000080E7, 32'h100, 3'b000, 1'b0, w);
    instr_valid = 1'b0;
    drain();

    // flush in ONE drops an instruction that would otherwise be accepted
    dec_ready = 1'b0;
    send(32'h00500093, 32'h200, 3'b000, 1'b0, w);
    instr = 32'h008000EF; pc = 32'h204; instr_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; instr_valid = 1'b0;
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("flush1_dec_valid", 32'(dec_valid), 32'd0);

    // issue during flush still completes and counts
    chk("pre_ill_cnt", 32'(ill_cnt), 32'd0);
    send(32'h0000007F, 32'h300, 3'b111, 1'b1, w);
    instr_valid = 1'b0; dec_ready = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    sb.delete();
    chk("flush_issue_cnt", 32'(ill_cnt), 32'd1);

    // illegal stream, counter saturates
    for (int n = 0; n < 200; n++) send(32'h0000007F, 32'h400 + 32'(n * 4), 3'b111, 1'b1, w);
    instr_valid = 1'b0;
    drain();
    @(posedge clk); #1;
    chk("ill_cnt_201", 32'(ill_cnt), 32'd201);
    for (int n = 0; n < 100; n++) send(32'h0000007F, 32'h800 + 32'(n * 4), 3'b111, 1'b1, w);
    instr_valid = 1'b0;
    drain();
    @(posedge clk); #1;
    chk("ill_cnt_sat", 32'(ill_cnt), 32'd255);

    // reset while FULL
    dec_ready = 1'b0;
    send(32'h00112023, 32'hA00, 3'b001, 1'b0, w);
    send(32'h0000007F, 32'hA04, 3'b111, 1'b1, w);
    instr_valid = 1'b0; dec_ready = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("rst2_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst2_instr_ready", 32'(instr_ready), 32'd1);
    chk("rst2_InstrD", InstrD, 32'd0);
    chk("rst2_PCD", PCD, 32'd0);
    chk("rst2_ImmSrcD", 32'(ImmSrcD), 32'd7);
    chk("rst2_illegal", 32'(illegal), 32'd0);
    chk("rst2_ill_cnt", 32'(ill_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
